// File: rtl/l1d_mshr_controller.sv
`default_nettype none
// ============================================================================
// Module   : l1d_mshr_controller
// Desc     : L1 data-cache miss-status controller. Tracks outstanding line
//            misses, merges secondary misses into the owning entry, issues
//            one lower-cache line request per primary miss and replays the
//            queued targets in arrival order once the line is filled.
// Options  : L1D_MSHR_STATS_EN adds saturating primary/merge/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module l1d_mshr_controller #(
   parameter int B          = 64,
   parameter int PADDR_BITS = 22,
   parameter int MSHR_COUNT = 4,
   parameter int TARGETS    = 4,
   parameter int TAG_BITS   = 10
) (
   input  logic                  clk_in,
   input  logic                  rst_N_in,
   input  logic                  miss_valid_in,
   output logic                  miss_ready_out,
   input  logic [PADDR_BITS-1:0] miss_paddr_in,
   input  logic                  miss_we_in,
   input  logic [63:0]           miss_data_in,
   input  logic [TAG_BITS-1:0]   miss_tag_in,
   output logic                  lc_req_valid_out,
   input  logic                  lc_req_ready_in,
   output logic [PADDR_BITS-1:0] lc_req_addr_out,
   input  logic                  fill_valid_in,
   output logic                  fill_ready_out,
   input  logic [PADDR_BITS-1:0] fill_addr_in,
   output logic                  replay_valid_out,
   input  logic                  replay_ready_in,
   output logic [PADDR_BITS-1:0] replay_paddr_out,
   output logic                  replay_we_out,
   output logic [63:0]           replay_data_out,
   output logic [TAG_BITS-1:0]   replay_tag_out,
`ifdef L1D_MSHR_STATS_EN
   output logic [31:0]           stat_primary_out,
   output logic [31:0]           stat_merge_out,
   output logic [31:0]           stat_stall_out,
`endif
   output logic                  full_out,
   output logic                  busy_out
);

   localparam int c_OFF_BITS  = $clog2(B);
   localparam int c_LINE_BITS = PADDR_BITS - c_OFF_BITS;
   localparam int c_ENT_W     = (MSHR_COUNT > 1) ? $clog2(MSHR_COUNT) : 1;
   localparam int c_IDX_W     = (TARGETS > 1) ? $clog2(TARGETS) : 1;
   localparam int c_CNT_W     = $clog2(TARGETS + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TARGETS);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_REPLAY = 2'd3
   } entry_state_t;

   // Entry storage
   entry_state_t          r_state     [MSHR_COUNT];
   entry_state_t          w_state_nxt [MSHR_COUNT];
   logic [c_LINE_BITS-1:0] r_line     [MSHR_COUNT];
   logic [c_CNT_W-1:0]    r_count     [MSHR_COUNT];
   logic [PADDR_BITS-1:0] r_t_paddr   [MSHR_COUNT][TARGETS];
   logic                  r_t_we      [MSHR_COUNT][TARGETS];
   logic [63:0]           r_t_data    [MSHR_COUNT][TARGETS];
   logic [TAG_BITS-1:0]   r_t_tag     [MSHR_COUNT][TARGETS];

   // Lower-cache request register and replay pointer
   logic                  r_lc_valid;
   logic [PADDR_BITS-1:0] r_lc_addr;
   logic [c_ENT_W-1:0]    r_lc_ent;
   logic [c_ENT_W-1:0]    r_rp_ent;
   logic [c_IDX_W-1:0]    r_rp_idx;

   // Lookup results
   logic [c_LINE_BITS-1:0] w_miss_line;
   logic [c_LINE_BITS-1:0] w_fill_line;
   logic [c_OFF_BITS-1:0]  w_fill_off_unused;
   logic                   w_hit, w_free_found, w_issue_found, w_fill_hit;
   logic                   w_any_replay, w_any_busy;
   logic [c_ENT_W-1:0]     w_hit_ent, w_free_ent, w_issue_ent, w_fill_ent;
   logic                   w_hit_open;
   logic [c_IDX_W-1:0]     w_merge_slot;
   logic                   w_miss_fire, w_alloc, w_merge;
   logic                   w_lc_fire, w_fill_fire, w_rp_valid, w_rp_fire, w_rp_last;

   assign w_miss_line       = miss_paddr_in[PADDR_BITS-1:c_OFF_BITS];
   assign w_fill_line       = fill_addr_in[PADDR_BITS-1:c_OFF_BITS];
   assign w_fill_off_unused = fill_addr_in[c_OFF_BITS-1:0];

   // Associative search over all entries for miss/fill matches and free/issue picks
   always_comb begin
      w_hit         = 1'b0;
      w_hit_ent     = '0;
      w_free_found  = 1'b0;
      w_free_ent    = '0;
      w_issue_found = 1'b0;
      w_issue_ent   = '0;
      w_fill_hit    = 1'b0;
      w_fill_ent    = '0;
      w_any_replay  = 1'b0;
      w_any_busy    = 1'b0;
      for (int i = 0; i < MSHR_COUNT; i++) begin
         if (r_state[i] != S_FREE) begin
            w_any_busy = 1'b1;
            if (r_line[i] == w_miss_line) begin
               w_hit     = 1'b1;
               w_hit_ent = c_ENT_W'(i);
            end
         end
         if ((r_state[i] == S_FREE) && !w_free_found) begin
            w_free_found = 1'b1;
            w_free_ent   = c_ENT_W'(i);
         end
         if ((r_state[i] == S_ISSUE) && !w_issue_found) begin
            w_issue_found = 1'b1;
            w_issue_ent   = c_ENT_W'(i);
         end
         if ((r_state[i] == S_WAIT) && (r_line[i] == w_fill_line) && !w_fill_hit) begin
            w_fill_hit = 1'b1;
            w_fill_ent = c_ENT_W'(i);
         end
         if (r_state[i] == S_REPLAY) begin
            w_any_replay = 1'b1;
         end
      end
   end

   // A matching entry absorbs the miss only before its line comes back and while slots remain
   assign w_hit_open     = ((r_state[w_hit_ent] == S_ISSUE) || (r_state[w_hit_ent] == S_WAIT)) &&
                           (r_count[w_hit_ent] < c_CNT_MAX);
   assign miss_ready_out = w_hit ? w_hit_open : w_free_found;
   assign w_miss_fire    = miss_valid_in & miss_ready_out;
   assign w_alloc        = w_miss_fire & ~w_hit;
   assign w_merge        = w_miss_fire & w_hit;
   assign w_merge_slot   = r_count[w_hit_ent][c_IDX_W-1:0];

   assign w_lc_fire      = r_lc_valid & lc_req_ready_in;
   assign fill_ready_out = ~w_any_replay;
   assign w_fill_fire    = fill_valid_in & fill_ready_out;

   // Only one entry can be in REPLAY, so a single pointer tracks it
   assign w_rp_valid = (r_state[r_rp_ent] == S_REPLAY);
   assign w_rp_fire  = w_rp_valid & replay_ready_in;
   assign w_rp_last  = ((c_CNT_W'(r_rp_idx) + c_CNT_W'(1)) == r_count[r_rp_ent]);

   // Entry next-state: each event targets an entry in a distinct state, so they never collide
   always_comb begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
         w_state_nxt[i] = r_state[i];
      end
      if (w_alloc) begin
         w_state_nxt[w_free_ent] = S_ISSUE;
      end
      if (w_lc_fire) begin
         w_state_nxt[r_lc_ent] = S_WAIT;
      end
      if (w_fill_fire && w_fill_hit) begin
         w_state_nxt[w_fill_ent] = S_REPLAY;
      end
      if (w_rp_fire && w_rp_last) begin
         w_state_nxt[r_rp_ent] = S_FREE;
      end
   end

   // Entry state register
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         for (int i = 0; i < MSHR_COUNT; i++) begin
            r_state[i] <= S_FREE;
         end
      end else begin
         for (int i = 0; i < MSHR_COUNT; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // Target counts: set on allocation, bumped on merge, cleared when the entry frees
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         for (int i = 0; i < MSHR_COUNT; i++) begin
            r_count[i] <= '0;
         end
      end else begin
         if (w_alloc) begin
            r_count[w_free_ent] <= c_CNT_W'(1);
         end
         if (w_merge) begin
            r_count[w_hit_ent] <= r_count[w_hit_ent] + c_CNT_W'(1);
         end
         if (w_rp_fire && w_rp_last) begin
            r_count[r_rp_ent] <= '0;
         end
      end
   end

   // Line address and target payload; only meaningful while the entry is not FREE
   always_ff @(posedge clk_in) begin
      if (w_alloc) begin
         r_line[w_free_ent]       <= w_miss_line;
         r_t_paddr[w_free_ent][0] <= miss_paddr_in;
         r_t_we[w_free_ent][0]    <= miss_we_in;
         r_t_data[w_free_ent][0]  <= miss_data_in;
         r_t_tag[w_free_ent][0]   <= miss_tag_in;
      end
      if (w_merge) begin
         r_t_paddr[w_hit_ent][w_merge_slot] <= miss_paddr_in;
         r_t_we[w_hit_ent][w_merge_slot]    <= miss_we_in;
         r_t_data[w_hit_ent][w_merge_slot]  <= miss_data_in;
         r_t_tag[w_hit_ent][w_merge_slot]   <= miss_tag_in;
      end
   end

   // Single outstanding lower-cache request, held stable until accepted
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         r_lc_valid <= 1'b0;
         r_lc_addr  <= '0;
         r_lc_ent   <= '0;
      end else if (w_lc_fire) begin
         r_lc_valid <= 1'b0;
      end else if (!r_lc_valid && w_issue_found) begin
         r_lc_valid <= 1'b1;
         r_lc_addr  <= {r_line[w_issue_ent], {c_OFF_BITS{1'b0}}};
         r_lc_ent   <= w_issue_ent;
      end
   end

   // Replay pointer: restarts at slot 0 on a matching fill, advances per accepted beat
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         r_rp_ent <= '0;
         r_rp_idx <= '0;
      end else if (w_fill_fire && w_fill_hit) begin
         r_rp_ent <= w_fill_ent;
         r_rp_idx <= '0;
      end else if (w_rp_fire) begin
         r_rp_idx <= r_rp_idx + c_IDX_W'(1);
      end
   end

   assign lc_req_valid_out = r_lc_valid;
   assign lc_req_addr_out  = r_lc_addr;
   assign replay_valid_out = w_rp_valid;
   assign replay_paddr_out = w_rp_valid ? r_t_paddr[r_rp_ent][r_rp_idx] : '0;
   assign replay_we_out    = w_rp_valid ? r_t_we[r_rp_ent][r_rp_idx]    : 1'b0;
   assign replay_data_out  = w_rp_valid ? r_t_data[r_rp_ent][r_rp_idx]  : 64'd0;
   assign replay_tag_out   = w_rp_valid ? r_t_tag[r_rp_ent][r_rp_idx]   : '0;
   assign full_out         = ~w_free_found;
   assign busy_out         = w_any_busy;

`ifdef L1D_MSHR_STATS_EN
   logic [31:0] r_stat_primary;
   logic [31:0] r_stat_merge;
   logic [31:0] r_stat_stall;

   // Saturating miss-path event counters
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         r_stat_primary <= 32'd0;
         r_stat_merge   <= 32'd0;
         r_stat_stall   <= 32'd0;
      end else begin
         if (w_alloc && (r_stat_primary != 32'hFFFF_FFFF)) begin
            r_stat_primary <= r_stat_primary + 32'd1;
         end
         if (w_merge && (r_stat_merge != 32'hFFFF_FFFF)) begin
            r_stat_merge <= r_stat_merge + 32'd1;
         end
         if (miss_valid_in && !miss_ready_out && (r_stat_stall != 32'hFFFF_FFFF)) begin
            r_stat_stall <= r_stat_stall + 32'd1;
         end
      end
   end

   assign stat_primary_out = r_stat_primary;
   assign stat_merge_out   = r_stat_merge;
   assign stat_stall_out   = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1d_mshr_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1d_mshr_controller
// Desc     : Scoreboard bench for l1d_mshr_controller. Expected lower-cache
//            requests and replay beats are queued as stimulus is driven and
//            compared against the beats observed on the DUT handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1d_mshr_controller;

   typedef struct packed {
      logic [21:0] paddr;
      logic        we;
      logic [63:0] data;
      logic [9:0]  tag;
   } beat_t;

   logic        clk_in = 1'b0;
   logic        rst_N_in;
   logic        miss_valid_in;
   logic        miss_ready_out;
   logic [21:0] miss_paddr_in;
   logic        miss_we_in;
   logic [63:0] miss_data_in;
   logic [9:0]  miss_tag_in;
   logic        lc_req_valid_out;
   logic        lc_req_ready_in;
   logic [21:0] lc_req_addr_out;
   logic        fill_valid_in;
   logic        fill_ready_out;
   logic [21:0] fill_addr_in;
   logic        replay_valid_out;
   logic        replay_ready_in;
   logic [21:0] replay_paddr_out;
   logic        replay_we_out;
   logic [63:0] replay_data_out;
   logic [9:0]  replay_tag_out;
   logic        full_out;
   logic        busy_out;

   int total = 0;
   int bad   = 0;

   logic [21:0] exp_lc[$];
   logic [21:0] obs_lc[$];
   beat_t       exp_rp[$];
   beat_t       obs_rp[$];

   l1d_mshr_controller dut (
      .clk_in           (clk_in),
      .rst_N_in         (rst_N_in),
      .miss_valid_in    (miss_valid_in),
      .miss_ready_out   (miss_ready_out),
      .miss_paddr_in    (miss_paddr_in),
      .miss_we_in       (miss_we_in),
      .miss_data_in     (miss_data_in),
      .miss_tag_in      (miss_tag_in),
      .lc_req_valid_out (lc_req_valid_out),
      .lc_req_ready_in  (lc_req_ready_in),
      .lc_req_addr_out  (lc_req_addr_out),
      .fill_valid_in    (fill_valid_in),
      .fill_ready_out   (fill_ready_out),
      .fill_addr_in     (fill_addr_in),
      .replay_valid_out (replay_valid_out),
      .replay_ready_in  (replay_ready_in),
      .replay_paddr_out (replay_paddr_out),
      .replay_we_out    (replay_we_out),
      .replay_data_out  (replay_data_out),
      .replay_tag_out   (replay_tag_out),
      .full_out         (full_out),
      .busy_out         (busy_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic beat_t mk(input logic [21:0] a, input logic we, input logic [63:0] d,
                                input logic [9:0] t);
      beat_t b;
      b.paddr = a;
      b.we    = we;
      b.data  = d;
      b.tag   = t;
      return b;
   endfunction

   // One clock: sample handshakes on the falling edge, return just after the rising edge
   task automatic tick(output bit macc, output bit facc);
      @(negedge clk_in);
      macc = miss_valid_in && miss_ready_out;
      facc = fill_valid_in && fill_ready_out;
      if (lc_req_valid_out && lc_req_ready_in) obs_lc.push_back(lc_req_addr_out);
      if (replay_valid_out && replay_ready_in)
         obs_rp.push_back(mk(replay_paddr_out, replay_we_out, replay_data_out, replay_tag_out));
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      bit ma, fa;
      for (int i = 0; i < n; i++) tick(ma, fa);
   endtask

   task automatic send_miss(input logic [21:0] a, input logic we, input logic [63:0] d,
                            input logic [9:0] t);
      bit ma, fa, ok;
      ok = 1'b0;
      miss_paddr_in = a; miss_we_in = we; miss_data_in = d; miss_tag_in = t;
      miss_valid_in = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         tick(ma, fa);
         ok = ma;
      end
      miss_valid_in = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL miss_accept addr=%h got=timeout want=accepted", a); end
   endtask

   task automatic send_fill(input logic [21:0] a);
      bit ma, fa, ok;
      ok = 1'b0;
      fill_addr_in  = a;
      fill_valid_in = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         tick(ma, fa);
         ok = fa;
      end
      fill_valid_in = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL fill_accept addr=%h got=timeout want=accepted", a); end
   endtask

   task automatic test_reset();
      bit ma, fa;
      repeat (3) @(posedge clk_in);
      #1;
      for (int ph = 0; ph < 2; ph++) begin
         total++;
         if ({miss_ready_out, fill_ready_out, lc_req_valid_out, replay_valid_out, full_out, busy_out}
             !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags phase=%0d got=%b want=110000", ph,
                     {miss_ready_out, fill_ready_out, lc_req_valid_out, replay_valid_out, full_out, busy_out});
         end
         total++;
         if ({lc_req_addr_out, replay_paddr_out, replay_we_out, replay_data_out, replay_tag_out} !== '0) begin
            bad++;
            $display("FAIL reset_data phase=%0d got lc=%h rp=%h tag=%h want=0", ph,
                     lc_req_addr_out, replay_paddr_out, replay_tag_out);
         end
         if (ph == 0) begin
            rst_N_in = 1'b1;
            tick(ma, fa);
         end
      end
   endtask

   task automatic test_single();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      exp_lc.push_back(22'h00040);
      exp_rp.push_back(mk(22'h00040, 1'b0, 64'd0, 10'd5));
      send_miss(22'h00040, 1'b0, 64'd0, 10'd5);
      idle(4);
      send_fill(22'h00040);
      total++;
      if (replay_valid_out !== 1'b1) begin
         bad++; $display("FAIL single_latency got=%b want=1", replay_valid_out);
      end
      idle(3);
      total++;
      if (busy_out !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy_out); end
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size()) begin
         bad++; $display("FAIL single_counts got lc=%0d rp=%0d want lc=%0d rp=%0d",
                         obs_lc.size(), obs_rp.size(), exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL single_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL single_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   task automatic test_merge();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      exp_lc.push_back(22'h00100);
      exp_rp.push_back(mk(22'h00100, 1'b0, 64'd0, 10'd1));
      exp_rp.push_back(mk(22'h00108, 1'b1, 64'hDEAD, 10'd2));
      exp_rp.push_back(mk(22'h00110, 1'b0, 64'd0, 10'd3));
      send_miss(22'h00100, 1'b0, 64'd0, 10'd1);
      send_miss(22'h00108, 1'b1, 64'hDEAD, 10'd2);
      send_miss(22'h00110, 1'b0, 64'd0, 10'd3);
      idle(4);
      send_fill(22'h00100);
      idle(5);
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size()) begin
         bad++; $display("FAIL merge_counts got lc=%0d rp=%0d want lc=%0d rp=%0d",
                         obs_lc.size(), obs_rp.size(), exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL merge_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL merge_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   task automatic test_full();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      bit ma, fa, stalled, acc;
      int rp_at_acc;
      for (int i = 0; i < 4; i++) begin
         exp_lc.push_back(22'(i * 64));
         send_miss(22'(i * 64), 1'b0, 64'd0, 10'(10 + i));
      end
      total++;
      if (full_out !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full_out); end
      exp_lc.push_back(22'h00100);
      exp_rp.push_back(mk(22'h00040, 1'b0, 64'd0, 10'd11));
      miss_paddr_in = 22'h00100; miss_we_in = 1'b0; miss_data_in = 64'd0; miss_tag_in = 10'd14;
      miss_valid_in = 1'b1;
      stalled = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(ma, fa);
         if (ma) stalled = 1'b0;
      end
      total++;
      if (!stalled || miss_ready_out !== 1'b0) begin
         bad++; $display("FAIL full_stall got ready=%b want=0", miss_ready_out);
      end
      fill_addr_in = 22'h00040; fill_valid_in = 1'b1;
      acc = 1'b0; rp_at_acc = -1;
      for (int i = 0; i < 40 && !acc; i++) begin
         tick(ma, fa);
         if (fa) fill_valid_in = 1'b0;
         if (ma) begin acc = 1'b1; rp_at_acc = obs_rp.size(); end
      end
      miss_valid_in = 1'b0; fill_valid_in = 1'b0;
      total++;
      if (!acc || rp_at_acc != 1) begin
         bad++; $display("FAIL full_realloc got acc=%b replays=%0d want acc=1 replays=1", acc, rp_at_acc);
      end
      idle(4);
      total++;
      if (full_out !== 1'b1) begin bad++; $display("FAIL full_refill got=%b want=1", full_out); end
      exp_rp.push_back(mk(22'h00000, 1'b0, 64'd0, 10'd10));
      exp_rp.push_back(mk(22'h00080, 1'b0, 64'd0, 10'd12));
      exp_rp.push_back(mk(22'h000C0, 1'b0, 64'd0, 10'd13));
      exp_rp.push_back(mk(22'h00100, 1'b0, 64'd0, 10'd14));
      send_fill(22'h00000); idle(3);
      send_fill(22'h00080); idle(3);
      send_fill(22'h000C0); idle(3);
      send_fill(22'h00100); idle(3);
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size() || busy_out !== 1'b0) begin
         bad++; $display("FAIL full_counts got lc=%0d rp=%0d busy=%b want lc=%0d rp=%0d busy=0",
                         obs_lc.size(), obs_rp.size(), busy_out, exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL full_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL full_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   task automatic test_overflow();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      bit ma, fa, stalled, acc;
      int rp_at_acc;
      exp_lc.push_back(22'h00200);
      exp_lc.push_back(22'h00200);
      for (int i = 0; i < 4; i++) begin
         exp_rp.push_back(mk(22'(32'h200 + i * 8), 1'b0, 64'(100 + i), 10'(20 + i)));
         send_miss(22'(32'h200 + i * 8), 1'b0, 64'(100 + i), 10'(20 + i));
      end
      miss_paddr_in = 22'h00220; miss_we_in = 1'b1; miss_data_in = 64'h5A5A; miss_tag_in = 10'd24;
      miss_valid_in = 1'b1;
      stalled = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(ma, fa);
         if (ma) stalled = 1'b0;
      end
      total++;
      if (!stalled || miss_ready_out !== 1'b0) begin
         bad++; $display("FAIL ovf_stall got ready=%b want=0", miss_ready_out);
      end
      fill_addr_in = 22'h00200; fill_valid_in = 1'b1;
      acc = 1'b0; rp_at_acc = -1;
      for (int i = 0; i < 40 && !acc; i++) begin
         tick(ma, fa);
         if (fa) fill_valid_in = 1'b0;
         if (ma) begin acc = 1'b1; rp_at_acc = obs_rp.size(); end
      end
      miss_valid_in = 1'b0; fill_valid_in = 1'b0;
      total++;
      if (!acc || rp_at_acc != 4) begin
         bad++; $display("FAIL ovf_realloc got acc=%b replays=%0d want acc=1 replays=4", acc, rp_at_acc);
      end
      exp_rp.push_back(mk(22'h00220, 1'b1, 64'h5A5A, 10'd24));
      idle(4);
      send_fill(22'h00200);
      idle(3);
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size()) begin
         bad++; $display("FAIL ovf_counts got lc=%0d rp=%0d want lc=%0d rp=%0d",
                         obs_lc.size(), obs_rp.size(), exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL ovf_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL ovf_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   task automatic test_drop_and_backpressure();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      bit ma, fa;
      send_fill(22'h00400);
      idle(3);
      total++;
      if (obs_rp.size() != 0 || busy_out !== 1'b0 || fill_ready_out !== 1'b1) begin
         bad++; $display("FAIL drop_fill got replays=%0d busy=%b fready=%b want 0/0/1",
                         obs_rp.size(), busy_out, fill_ready_out);
      end
      exp_lc.push_back(22'h00500);
      exp_rp.push_back(mk(22'h00500, 1'b0, 64'd0, 10'd30));
      exp_rp.push_back(mk(22'h00508, 1'b1, 64'h1234, 10'd31));
      exp_rp.push_back(mk(22'h00510, 1'b0, 64'd0, 10'd32));
      send_miss(22'h00500, 1'b0, 64'd0, 10'd30);
      send_miss(22'h00508, 1'b1, 64'h1234, 10'd31);
      send_miss(22'h00510, 1'b0, 64'd0, 10'd32);
      idle(4);
      replay_ready_in = 1'b0;
      send_fill(22'h00500);
      tick(ma, fa);
      replay_ready_in = 1'b1;
      tick(ma, fa);
      replay_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(ma, fa);
         total++;
         if (replay_valid_out !== 1'b1 || replay_paddr_out !== 22'h00508 || replay_tag_out !== 10'd31 ||
             replay_data_out !== 64'h1234) begin
            bad++; $display("FAIL hold_beat cyc=%0d got v=%b a=%h tag=%0d want v=1 a=00508 tag=31",
                            i, replay_valid_out, replay_paddr_out, replay_tag_out);
         end
      end
      replay_ready_in = 1'b1;
      idle(4);
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size()) begin
         bad++; $display("FAIL hold_counts got lc=%0d rp=%0d want lc=%0d rp=%0d",
                         obs_lc.size(), obs_rp.size(), exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL hold_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL hold_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   task automatic test_reset_mid_replay();
      logic [21:0] ga, ea;
      beat_t gb, eb;
      bit ma, fa;
      exp_lc.push_back(22'h00600);
      exp_rp.push_back(mk(22'h00600, 1'b0, 64'd0, 10'd40));
      send_miss(22'h00600, 1'b0, 64'd0, 10'd40);
      send_miss(22'h00604, 1'b0, 64'd0, 10'd41);
      send_miss(22'h00608, 1'b0, 64'd0, 10'd42);
      idle(4);
      send_fill(22'h00600);
      tick(ma, fa);
      rst_N_in = 1'b0;
      #1;
      total++;
      if ({miss_ready_out, fill_ready_out, lc_req_valid_out, replay_valid_out, full_out, busy_out}
          !== 6'b110000) begin
         bad++; $display("FAIL midrst_flags got=%b want=110000",
                         {miss_ready_out, fill_ready_out, lc_req_valid_out, replay_valid_out, full_out, busy_out});
      end
      total++;
      if ({lc_req_addr_out, replay_paddr_out, replay_we_out, replay_data_out, replay_tag_out} !== '0) begin
         bad++; $display("FAIL midrst_data got lc=%h rp=%h tag=%h want=0",
                         lc_req_addr_out, replay_paddr_out, replay_tag_out);
      end
      idle(2);
      rst_N_in = 1'b1;
      idle(8);
      total++;
      if (obs_lc.size() != exp_lc.size() || obs_rp.size() != exp_rp.size() || busy_out !== 1'b0) begin
         bad++; $display("FAIL midrst_counts got lc=%0d rp=%0d busy=%b want lc=%0d rp=%0d busy=0",
                         obs_lc.size(), obs_rp.size(), busy_out, exp_lc.size(), exp_rp.size());
      end
      while (obs_lc.size() > 0 && exp_lc.size() > 0) begin
         ga = obs_lc.pop_front(); ea = exp_lc.pop_front(); total++;
         if (ga !== ea) begin bad++; $display("FAIL midrst_lc got=%h want=%h", ga, ea); end
      end
      while (obs_rp.size() > 0 && exp_rp.size() > 0) begin
         gb = obs_rp.pop_front(); eb = exp_rp.pop_front(); total++;
         if (gb !== eb) begin bad++; $display("FAIL midrst_replay got=%h want=%h", gb, eb); end
      end
      obs_lc.delete(); exp_lc.delete(); obs_rp.delete(); exp_rp.delete();
   endtask

   initial begin
      rst_N_in        = 1'b0;
      miss_valid_in   = 1'b0;
      miss_paddr_in   = '0;
      miss_we_in      = 1'b0;
      miss_data_in    = '0;
      miss_tag_in     = '0;
      lc_req_ready_in = 1'b1;
      fill_valid_in   = 1'b0;
      fill_addr_in    = '0;
      replay_ready_in = 1'b1;
      test_reset();
      test_single();
      test_merge();
      test_full();
      test_overflow();
      test_drop_and_backpressure();
      test_reset_mid_replay();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/l1d_mshr_controller.md
Name: l1d_mshr_controller

Overview:
- Miss-status controller for the L1 data cache.
- Tracks outstanding line misses in MSHR_COUNT entries, and merges secondary misses to the same line into the owning entry's target list.
- Issues one line request per primary miss to the lower cache.
- On refill, replays every queued target in arrival order to the cache/LSU side, then frees the entry.
- Sits between the cache storage miss output, the lower-cache request/fill channels, and the L1D response path.

Parameters:
- B, 64, line size in bytes (power of two); line address = paddr >> log2(B).
- PADDR_BITS, 22, physical address width.
- MSHR_COUNT, 4, number of entries.
- TARGETS, 4, max queued requests per entry.
- TAG_BITS, 10, processor request tag width.

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  asynchronous active-low reset
- miss_valid_in  in  1  miss request valid
- miss_ready_out  out  1  controller can accept miss this cycle
- miss_paddr_in  in  PADDR_BITS  miss physical address
- miss_we_in  in  1  miss is a store
- miss_data_in  in  64  store data
- miss_tag_in  in  TAG_BITS  processor tag
- lc_req_valid_out  out  1  line request to lower cache
- lc_req_ready_in  in  1  lower cache accepts request
- lc_req_addr_out  out  PADDR_BITS  line-aligned address (offset bits zero)
- fill_valid_in  in  1  lower cache returned a line
- fill_ready_out  out  1  controller can accept fill
- fill_addr_in  in  PADDR_BITS  fill address (offset bits ignored)
- replay_valid_out  out  1  replayed target valid
- replay_ready_in  in  1  consumer accepts replay
- replay_paddr_out  out  PADDR_BITS  target address
- replay_we_out  out  1  target is store
- replay_data_out  out  64  store data
- replay_tag_out  out  TAG_BITS  target tag
- full_out  out  1  no FREE entry
- busy_out  out  1  any entry not FREE

Behaviour:
- Reset: asynchronous, active-low. All entries FREE, all target counts 0. All outputs 0, except miss_ready_out=1 and fill_ready_out=1. Reset mid-operation discards all entries and any in-flight replay; no further lc_req or replay beats are produced.
- Entry states: FREE -> ISSUE -> WAIT -> REPLAY -> FREE.
- Each entry holds a line address, a target count (0..TARGETS), and TARGETS slots of {paddr, we, data, tag}.
- Miss lookup is combinational on miss_paddr_in's line address against non-FREE entries.
  - Match in ISSUE or WAIT with count<TARGETS: merge. Target is appended at slot=count, count++.
  - Match with count==TARGETS, or match in REPLAY: stall (miss_ready_out=0).
  - No match: allocate the lowest-index FREE entry to ISSUE, target in slot 0, count=1.
  - No match and no FREE entry: stall.
- A miss is accepted on miss_valid_in & miss_ready_out; entry state updates on that clock edge.
- Issue: the lowest-index ISSUE entry drives lc_req_valid_out/lc_req_addr_out (registered, stable until handshake). On lc_req_valid_out & lc_req_ready_in the entry moves to WAIT. Only one request is outstanding on the bus at a time.
- Fill:
  - fill_ready_out=1 iff no entry is in REPLAY.
  - On a fill handshake, the WAIT entry with matching line address moves to REPLAY, replay index=0.
  - A fill that matches no WAIT entry is accepted and dropped.
- Replay:
  - The REPLAY entry presents slot[index] on replay_*; replay_valid_out=1.
  - On replay_ready_in, index++.
  - Once the beat at index count-1 is accepted, the entry goes FREE on the same edge and replay_valid_out=0 the next cycle.
  - Replay latency: first beat is valid the cycle after the fill handshake.
- Simultaneous events:
  - Merge and fill to the same WAIT entry in one cycle: both accepted. The merged target is included in the replay, since the count is read live.
  - Allocation and freeing in the same cycle: the freed entry is not eligible for allocation until the next cycle.
  - Miss, issue and replay handshakes are independent and may all occur in one cycle.
- full_out and busy_out are combinational from entry states.

Optional Feature:
- Macro: L1D_MSHR_STATS_EN.
- Defined: adds three 32-bit output ports stat_primary_out, stat_merge_out and stat_stall_out.
  - stat_primary_out increments on each allocation.
  - stat_merge_out increments on each merge.
  - stat_stall_out increments on each cycle with miss_valid_in=1 and miss_ready_out=0.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load miss 0x00040 tag 5; lc_req_ready_in=1 -> lc_req_addr_out=0x00040 one request. Fill 0x00040 -> one replay {0x00040, we=0, tag 5}, entry FREE, busy_out=0.
- Misses 0x00100 (tag 1), store 0x00108 data 0xDEAD (tag 2), 0x00110 (tag 3) -> exactly one lc_req 0x00100. Fill -> replays tags 1,2,3 in order, tag 2 with we=1, data 0xDEAD.
- 4 misses to distinct lines 0x0000,0x0040,0x0080,0x00C0 -> full_out=1. A 5th miss 0x0100 stalls until the fill 0x0040 replay completes, then allocates entry 1.
- 5 misses to line 0x0200 with TARGETS=4 -> 5th stalls (miss_ready_out=0) until the replay drains. It then allocates a new entry and issues a second lc_req for 0x0200.
- Fill to 0x0400 with no matching entry -> accepted and dropped, no replay. Also: replay_ready_in held 0 for 3 cycles mid-replay -> replay beat held stable, no target lost.
- Reset asserted during replay of 3 targets after beat 1 -> all outputs 0 except miss_ready_out and fill_ready_out; no further replay beats after release.
